// File: rtl/sap1_mem_arbiter.sv
// Purpose: shares the SAP-1 single-port 16x8 memory between CPU reads and loader writes.
// Latency: CPU read req->rvalid 3 cycles (4-cycle slot); loader valid->ready 1 cycle (3-cycle slot).
// Backpressure: requests wait in IDLE until granted. Round-robin on ties, or strict loader priority with SAP1_ARB_LD_PRIORITY_EN.
module sap1_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU read port
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  // loader write port
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  // memory array port
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LD_MAX = DEPTH[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_RD,
    S_CPU_CAP,
    S_CPU_DONE,
    S_LD_WR,
    S_LD_ACK
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_t;

  state_t state;
  gnt_t   last_gnt;
  logic   ld_hold;
  logic   gnt_cpu;
  logic   gnt_ld;

  // Grant decision, only acted on while the FSM sits in IDLE.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ld  = 1'b0;
`ifdef SAP1_ARB_LD_PRIORITY_EN
    // Download mode: the loader always wins; the CPU is expected to be held.
    if (ld_valid) begin
      gnt_ld = 1'b1;
    end else if (cpu_req) begin
      gnt_cpu = 1'b1;
    end
`else
    // Round-robin: on a tie the side that was not served last wins.
    if (cpu_req && ld_valid) begin
      if (last_gnt == GNT_LD) begin
        gnt_cpu = 1'b1;
      end else begin
        gnt_ld = 1'b1;
      end
    end else if (cpu_req) begin
      gnt_cpu = 1'b1;
    end else if (ld_valid) begin
      gnt_ld = 1'b1;
    end
`endif
  end

  // Arbiter FSM; all strobes are registered so the memory sees clean pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_gnt   <= GNT_LD;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ld_ready   <= 1'b0;
      ld_count   <= '0;
      ld_hold    <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // single-cycle strobes fall back to zero unless a transition raises them
      cpu_rvalid <= 1'b0;
      ld_ready   <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_cpu) begin
            // address captured at grant; later cpu_addr changes are ignored
            state    <= S_CPU_RD;
            last_gnt <= GNT_CPU;
            mem_addr <= cpu_addr;
            mem_re   <= 1'b1;
          end else if (gnt_ld) begin
            // the write is performed and acknowledged in the same cycle
            state     <= S_LD_WR;
            last_gnt  <= GNT_LD;
            mem_addr  <= ld_addr;
            mem_wdata <= ld_data;
            mem_we    <= 1'b1;
            ld_ready  <= 1'b1;
            ld_hold   <= 1'b1;
            if (ld_count != LD_MAX) begin
              ld_count <= ld_count + (ADDR_W + 1)'(1);
            end
          end
        end
        S_CPU_RD: begin
          // memory returns data one cycle after mem_re
          state <= S_CPU_CAP;
        end
        S_CPU_CAP: begin
          cpu_rdata  <= mem_rdata;
          cpu_rvalid <= 1'b1;
          state      <= S_CPU_DONE;
        end
        S_CPU_DONE: begin
          // swallow the cycle where cpu_req is still high after rvalid
          state <= S_IDLE;
        end
        S_LD_WR: begin
          state <= S_LD_ACK;
        end
        S_LD_ACK: begin
          // swallow the cycle where ld_valid is still high after ready
          ld_hold <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          ld_hold <= 1'b0;
        end
      endcase
    end
  end

  // Freeze the control unit while the loader owns or is about to win the memory.
  // Held low while reset is asserted so the block presents its idle state.
  always_comb begin
    cpu_hold = ld_hold | (rst_n & ld_valid & (state == S_IDLE));
  end

  // Read and write strobes are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem_re && mem_we));
    end
  end

endmodule

// File: tb/tb_sap1_mem_arbiter.sv
// Directed bench for sap1_mem_arbiter with a small 16x8 memory model.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
// Expected values are hand-derived from the cycle timing of each transaction.
module tb_sap1_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_hold;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic [AW:0]   ld_count;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                              8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

  sap1_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_hold   (cpu_hold),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_count   (ld_count),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port memory: write on mem_we, registered read data after mem_re
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ph;
    int pulses;
    int pos0;
    int pos1;
    int we_seen;
    logic [AW:0] exp_cnt;

    // ---------------- reset with both requesters active
    cpu_req  = 1'b1;
    cpu_addr = 4'd5;
    ld_valid = 1'b1;
    ld_addr  = 4'd7;
    ld_data  = 8'hAA;
    step();
    step();
    check_eq("rst_rvalid", cpu_rvalid, 0);
    check_eq("rst_rdata", cpu_rdata, 0);
    check_eq("rst_ready", ld_ready, 0);
    check_eq("rst_count", ld_count, 0);
    check_eq("rst_re", mem_re, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_hold", cpu_hold, 0);

    // ---------------- continuous contention: C(7-cycle period: RD CAP DONE IDLE WR ACK IDLE)
    rst_n = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      ph = (c - 1) % 7;
      check_eq("arb_re", mem_re, (ph == 0) ? 1 : 0);
      check_eq("arb_we", mem_we, (ph == 4) ? 1 : 0);
      check_eq("arb_ready", ld_ready, (ph == 4) ? 1 : 0);
      check_eq("arb_rvalid", cpu_rvalid, (ph == 2) ? 1 : 0);
      check_eq("arb_hold", cpu_hold, (ph >= 3) ? 1 : 0);
      if (ph == 0) check_eq("arb_rd_addr", mem_addr, 5);
      if (ph == 2) check_eq("arb_rdata", cpu_rdata, 8'h15);
      if (ph == 4) begin
        check_eq("arb_wr_addr", mem_addr, 7);
        check_eq("arb_wdata", mem_wdata, 8'hAA);
      end
    end
    check_eq("arb_count", ld_count, 3);
    cpu_req  = 1'b0;
    ld_valid = 1'b0;
    step();
    check_eq("quiet_re", mem_re, 0);
    check_eq("quiet_we", mem_we, 0);
    check_eq("quiet_hold", cpu_hold, 0);

    // ---------------- loader writes 3=0x1E, then CPU reads 3
    ld_valid = 1'b1;
    ld_addr  = 4'd3;
    ld_data  = 8'h1E;
    step();
    check_eq("wr_we", mem_we, 1);
    check_eq("wr_ready", ld_ready, 1);
    check_eq("wr_addr", mem_addr, 3);
    check_eq("wr_wdata", mem_wdata, 8'h1E);
    check_eq("wr_count", ld_count, 4);
    check_eq("wr_hold", cpu_hold, 1);
    check_eq("wr_re", mem_re, 0);
    ld_addr = 4'd9;
    ld_data = 8'h55;
    step();
    check_eq("ack_ready", ld_ready, 0);
    check_eq("ack_we", mem_we, 0);
    check_eq("ack_hold", cpu_hold, 1);
    check_eq("ack_wdata_held", mem_wdata, 8'h1E);
    ld_valid = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 4'd3;
    step();
    check_eq("rd_idle_hold", cpu_hold, 0);
    check_eq("rd_idle_re", mem_re, 0);
    step();
    check_eq("rd_re", mem_re, 1);
    check_eq("rd_addr", mem_addr, 3);
    cpu_addr = 4'd9;
    step();
    check_eq("rd_cap_re", mem_re, 0);
    check_eq("rd_cap_rvalid", cpu_rvalid, 0);
    step();
    check_eq("rd_rvalid", cpu_rvalid, 1);
    check_eq("rd_rdata", cpu_rdata, 8'h1E);
    cpu_req = 1'b0;
    step();
    check_eq("rd_after_rvalid", cpu_rvalid, 0);
    check_eq("rd_rdata_held", cpu_rdata, 8'h1E);

    // ---------------- cpu_req held 8 cycles on one address
    cpu_req  = 1'b1;
    cpu_addr = 4'd3;
    pulses   = 0;
    pos0     = 0;
    pos1     = 0;
    we_seen  = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (mem_we) we_seen++;
      if (cpu_rvalid) begin
        pulses++;
        if (pulses == 1) pos0 = k;
        else pos1 = k;
      end
    end
    cpu_req = 1'b0;
    check_eq("hold8_pulses", pulses, 2);
    check_eq("hold8_first", pos0, 3);
    check_eq("hold8_gap", pos1 - pos0, 4);
    check_eq("hold8_no_we", we_seen, 0);
    step();
    check_eq("hold8_quiet", mem_re, 0);

    // ---------------- 17 loader writes after reset, count saturates at 16
    rst_n = 1'b0;
    step();
    check_eq("sat_rst_count", ld_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      ld_valid = 1'b1;
      ld_addr  = i[3:0];
      ld_data  = i[7:0];
      step();
      exp_cnt = (i + 1 > 16) ? 5'd16 : 5'(i + 1);
      check_eq("sat_count", ld_count, exp_cnt);
      step();
      ld_valid = 1'b0;
      step();
    end
    check_eq("sat_final", ld_count, 16);

    // ---------------- read back a loaded byte (addr 2 = 0x02)
    cpu_req  = 1'b1;
    cpu_addr = 4'd2;
    step();
    step();
    step();
    check_eq("ldrd_rvalid", cpu_rvalid, 1);
    check_eq("ldrd_rdata", cpu_rdata, 8'h02);
    cpu_req = 1'b0;
    step();

    // ---------------- reset during CPU_CAP aborts the read
    cpu_req  = 1'b1;
    cpu_addr = 4'd5;
    step();
    check_eq("abort_re", mem_re, 1);
    step();
    check_eq("abort_cap_rvalid", cpu_rvalid, 0);
    rst_n = 1'b0;
    step();
    check_eq("abort_rvalid", cpu_rvalid, 0);
    check_eq("abort_rdata", cpu_rdata, 0);
    check_eq("abort_re_low", mem_re, 0);
    check_eq("abort_we_low", mem_we, 0);
    check_eq("abort_ready", ld_ready, 0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_re", mem_re, 1);
    check_eq("post_rst_addr", mem_addr, 5);
    step();
    step();
    check_eq("post_rst_rvalid", cpu_rvalid, 1);
    check_eq("post_rst_rdata", cpu_rdata, 8'h05);
    cpu_req = 1'b0;
    step();
    check_eq("post_rst_done", cpu_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sap1_mem_arbiter.md
# sap1_mem_arbiter

Arbiter sharing the single-port 16x8 program/data memory of the SAP-1 CPU between two requesters: the CPU fetch/operand read path and an external program loader that writes bytes over a valid/ready handshake. It sits between the control unit/MAR on one side, the loader interface on the other, and the memory array below. All outputs are registered or decoded directly from the state register, so the memory sees glitch-free strobes.

## Interface
- ADDR_W, 4, memory address width (16 locations)
- DATA_W, 8, memory data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU read request (level); held until cpu_rvalid
- cpu_addr  in  ADDR_W  CPU read address; stable while cpu_req high
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  DATA_W  registered read data; holds last value
- cpu_hold  out  1  freeze request to control unit while loader owns memory
- ld_valid  in  1  loader write request; held until ld_ready
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_ready  out  1  one-cycle pulse; write accepted and performed
- ld_count  out  ADDR_W+1  number of accepted loader writes, saturates at 16
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re

## Operation
- States: IDLE, CPU_RD, CPU_CAP, CPU_DONE, LD_WR, LD_ACK.
- IDLE: sample cpu_req and ld_valid. Neither -> stay. One -> grant it. Both -> round-robin: grant the side not granted last (last_gnt register).
- CPU path: IDLE -> CPU_RD (mem_re=1, mem_addr=latched cpu_addr) -> CPU_CAP (cpu_rdata <= mem_rdata) -> CPU_DONE (cpu_rvalid=1) -> IDLE. last_gnt <= CPU.
- Loader path: IDLE -> LD_WR (mem_we=1, mem_addr/mem_wdata = latched ld_addr/ld_data, ld_ready=1) -> LD_ACK -> IDLE. last_gnt <= LD. ld_count increments in LD_WR unless already 16.
- CPU_DONE and LD_ACK ignore all requests. They absorb the cycle in which the requester still holds req/valid after its acknowledge, so one request is never served twice.
- cpu_hold = 1 in LD_WR and LD_ACK, and in IDLE whenever ld_valid is high. Otherwise 0.
- Address/data are latched at grant. Changes on the inputs after grant have no effect.
- mem_re and mem_we are never high together. mem_addr/mem_wdata hold their last value when unused.

## Timing
- Reset (rst_n low at a rising edge): state=IDLE, last_gnt=LD (CPU wins the first tie), cpu_rvalid=0, cpu_rdata=0, ld_ready=0, ld_count=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0.
- Reset mid-transaction aborts it: no rvalid/ready is issued and no strobe is high in the cycle after the reset edge.
- CPU read: cpu_req sampled in cycle T -> mem_re in T+1 -> cpu_rvalid in T+3 -> IDLE in T+4. Peak rate is one read per 4 cycles.
- Loader write: ld_valid sampled in T -> mem_we and ld_ready in T+1 -> IDLE in T+3. The loader drops or advances ld_valid in the cycle after it sees ld_ready.
- Contention: while both requesters are continuously pending, grants alternate CPU, LD, CPU, ... The worst-case wait is one transaction of the other side (3 or 4 cycles).
- Writing the address the CPU is waiting on is well defined, because transactions are serialized. A read granted after the write returns the new data.

## Configuration
- SAP1_ARB_LD_PRIORITY_EN defined: strict loader priority. In IDLE, ld_valid wins whenever high and last_gnt is ignored. The CPU can starve; this mode is intended for program download with the CPU held.
- Not defined: round-robin as described above.

## Test plan
- Reset with both requests high -> all outputs at the reset values listed above. First IDLE with both requests -> CPU granted (mem_re at T+1).
- Loader writes addr 3 = 0x1E, then CPU reads addr 3 -> mem_we at T+1 with mem_addr=3, mem_wdata=0x1E, ld_count=1. The read returns cpu_rdata=0x1E with cpu_rvalid at T+3.
- cpu_req held high for 8 cycles on one address -> exactly 2 rvalid pulses, 4 cycles apart, and mem_re is never adjacent to mem_we.
- Both requesters continuously pending for 20 cycles -> grants strictly alternate; cpu_hold is high during each LD_WR/LD_ACK.
- 17 loader writes -> ld_count saturates at 16. With SAP1_ARB_LD_PRIORITY_EN defined and both requesting, the loader is granted every time.
- rst_n asserted in the CPU_CAP cycle -> no cpu_rvalid, cpu_rdata=0, state IDLE, and the next request is served normally.
